// File: rtl/pe_pkg.sv
// Shared types and saturating-add helpers for the multiply-accumulate processing element.
// Values are carried in a 64-bit container so one helper serves every accumulator width.
package pe_pkg;

  localparam int MAX_ACC_W = 64;

  typedef enum logic {ACC_FIRST, ACC_ACCUM} acc_state_t;

  typedef logic [MAX_ACC_W-1:0] wide_t;

  // Largest representable accumulator value, sign-extended into the wide container.
  function automatic wide_t acc_max(input int unsigned w, input bit is_signed);
    return is_signed ? (wide_t'(1) << (w - 1)) - wide_t'(1)
                     : (wide_t'(1) << w) - wide_t'(1);
  endfunction

  function automatic wide_t acc_min(input int unsigned w, input bit is_signed);
    return is_signed ? ~((wide_t'(1) << (w - 1)) - wide_t'(1)) : '0;
  endfunction

  // Operands arrive already extended from w bits; returns {ovf, sum}. Callers keep sum[w-1:0].
  function automatic logic [MAX_ACC_W:0] sat_add(input wide_t a, input wide_t b,
                                                 input int unsigned w, input bit is_signed,
                                                 input bit sat);
    logic [MAX_ACC_W:0] sum;
    logic [MAX_ACC_W:0] hi;
    logic [MAX_ACC_W:0] lo;
    logic               ovf_hi;
    logic               ovf_lo;
    wide_t              res;
    hi = {1'b0, acc_max(w, is_signed)};
    lo = {is_signed, acc_min(w, is_signed)};
    if (is_signed) sum = {a[MAX_ACC_W-1], a} + {b[MAX_ACC_W-1], b};
    else           sum = {1'b0, a} + {1'b0, b};
    ovf_hi = is_signed ? ($signed(sum) > $signed(hi)) : (sum > hi);
    ovf_lo = is_signed && ($signed(sum) < $signed(lo));
    res    = sum[MAX_ACC_W-1:0];
    if (sat && ovf_hi)      res = acc_max(w, is_signed);
    else if (sat && ovf_lo) res = acc_min(w, is_signed);
    return {ovf_hi | ovf_lo, res};
  endfunction

endpackage

// File: rtl/pe_mac_param_if.sv
// Operand, forwarding and result-handshake bundle of one systolic cell.
// Signal names are from the cell's point of view; the cell takes the slave modport.
interface pe_mac_param_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
);

  logic              i_valid;
  logic              i_last;
  logic              i_clear;
  logic [DATA_W-1:0] i_a;
  logic [DATA_W-1:0] i_b;
  logic              o_valid;
  logic              o_last;
  logic [DATA_W-1:0] o_a;
  logic [DATA_W-1:0] o_b;
  logic [ACC_W-1:0]  o_y;
  logic              o_yValid;
  logic              i_yReady;
  logic              o_yOvf;
  logic              o_overrun;

  modport slave (
    input  i_valid, i_last, i_clear, i_a, i_b, i_yReady,
    output o_valid, o_last, o_a, o_b, o_y, o_yValid, o_yOvf, o_overrun
  );

  modport master (
    output i_valid, i_last, i_clear, i_a, i_b, i_yReady,
    input  o_valid, o_last, o_a, o_b, o_y, o_yValid, o_yOvf, o_overrun
  );

endinterface

// File: rtl/pe_sat_add.sv
// Combinational accumulator adder: signed/unsigned add with clamp or wrap and overflow flag.
module pe_sat_add
  import pe_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1
) (
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  wide_t              a_x;
  wide_t              b_x;
  logic [MAX_ACC_W:0] res;

  always_comb begin
    if (SIGNED != 0) begin
      a_x = wide_t'($signed(a));
      b_x = wide_t'($signed(b));
    end else begin
      a_x = wide_t'(a);
      b_x = wide_t'(b);
    end
    res = sat_add(a_x, b_x, ACC_W, SIGNED != 0, SATURATE != 0);
    sum = res[ACC_W-1:0];
    ovf = res[MAX_ACC_W];
  end

endmodule

// File: rtl/pe_mac_param.sv
// Systolic processing element: forwards operands east/south, accumulates a*b per tile and
// holds each finished dot product in a valid/ready result register.
module pe_mac_param
  import pe_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int SIGNED   = 0,
  parameter int SATURATE = 1,
  parameter int PIPE_MUL = 1
) (
  input logic          i_clk,
  input logic          i_arst_n,
  pe_mac_param_if.slave bus
);

  localparam int PROD_W = 2 * DATA_W;

  if (ACC_W < PROD_W || ACC_W > MAX_ACC_W) begin : g_bad_width
    $error("pe_mac_param: ACC_W must lie between 2*DATA_W and 64");
  end

  // ---------------- operand forwarding ----------------
  logic              fwd_valid_q;
  logic              fwd_last_q;
  logic [DATA_W-1:0] fwd_a_q;
  logic [DATA_W-1:0] fwd_b_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_last_q  <= 1'b0;
      fwd_a_q     <= '0;
      fwd_b_q     <= '0;
    end else begin
      fwd_valid_q <= bus.i_valid;
      if (bus.i_valid) begin
        fwd_last_q <= bus.i_last;
        fwd_a_q    <= bus.i_a;
        fwd_b_q    <= bus.i_b;
      end
    end
  end

  // ---------------- product ----------------
  logic [PROD_W-1:0] op_a_x;
  logic [PROD_W-1:0] op_b_x;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
  always_comb begin
    if (SIGNED != 0) begin
      op_a_x   = PROD_W'($signed(bus.i_a));
      op_b_x   = PROD_W'($signed(bus.i_b));
      prod     = op_a_x * op_b_x;
      prod_ext = ACC_W'($signed(prod));
    end else begin
      op_a_x   = PROD_W'(bus.i_a);
      op_b_x   = PROD_W'(bus.i_b);
      prod     = op_a_x * op_b_x;
      prod_ext = ACC_W'(prod);
    end
  end

  // Qualified product term (pv/pl/pp) seen by the accumulator, optionally one cycle late.
  logic             pv;
  logic             pl;
  logic [ACC_W-1:0] pp;

  if (PIPE_MUL != 0) begin : g_pipe
    logic             pv_q;
    logic             pl_q;
    logic [ACC_W-1:0] pp_q;

    // NOTE: all state here is plain flops with async reset; there is no memory to leave unreset.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        pv_q <= 1'b0;
        pl_q <= 1'b0;
        pp_q <= '0;
      end else begin
        pv_q <= bus.i_valid && !bus.i_clear;
        if (bus.i_valid) begin
          pl_q <= bus.i_last;
          pp_q <= prod_ext;
        end
      end
    end

    assign pv = pv_q;
    assign pl = pl_q;
    assign pp = pp_q;
  end else begin : g_comb
    assign pv = bus.i_valid;
    assign pl = bus.i_last;
    assign pp = prod_ext;
  end

  // ---------------- accumulator FSM ----------------
  acc_state_t       state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic [ACC_W-1:0] fin_sum;
  logic             fin_ovf;
  logic             load;

  pe_sat_add #(
    .ACC_W   (ACC_W),
    .SIGNED  (SIGNED),
    .SATURATE(SATURATE)
  ) u_sat_add (
    .a  (acc_q),
    .b  (pp),
    .sum(add_sum),
    .ovf(add_ovf)
  );

  // Running value including the current term; it is also the tile result when pl is set.
  always_comb begin
    if (state_q == ACC_FIRST) begin
      fin_sum = pp;
      fin_ovf = 1'b0;
    end else begin
      fin_sum = add_sum;
      fin_ovf = ovf_q | add_ovf;
    end
    load = pv && pl && !bus.i_clear;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= ACC_FIRST;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (bus.i_clear) begin
      state_q <= ACC_FIRST;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (pv) begin
      acc_q   <= fin_sum;
      ovf_q   <= fin_ovf;
      state_q <= pl ? ACC_FIRST : ACC_ACCUM;
    end
  end

  // ---------------- result register ----------------
  logic [ACC_W-1:0] y_q;
  logic             y_valid_q;
  logic             y_ovf_q;
  logic             overrun_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      y_ovf_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= load && y_valid_q && !bus.i_yReady;
      if (load) begin
        y_q       <= fin_sum;
        y_ovf_q   <= fin_ovf;
        y_valid_q <= 1'b1;
      end else if (y_valid_q && bus.i_yReady) begin
        y_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_valid   = fwd_valid_q;
  assign bus.o_last    = fwd_last_q;
  assign bus.o_a       = fwd_a_q;
  assign bus.o_b       = fwd_b_q;
  assign bus.o_y       = y_q;
  assign bus.o_yValid  = y_valid_q;
  assign bus.o_yOvf    = y_ovf_q;
  assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_pe_mac_param.sv
// Bench for pe_mac_param: four parameterisations share one stimulus stream and are compared
// every cycle against a tile-level arithmetic model, plus directed checks of known results.
module tb_pe_mac_param;

  localparam int NCFG = 4;
  // cfg0 default, cfg1 signed 16-bit saturating, cfg2 signed 16-bit wrapping, cfg3 no mul pipe
  localparam int CFG_W   [NCFG] = '{32, 16, 16, 32};
  localparam int CFG_S   [NCFG] = '{0, 1, 1, 0};
  localparam int CFG_SAT [NCFG] = '{1, 1, 0, 1};
  localparam int CFG_P   [NCFG] = '{1, 1, 1, 0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       drv_v, drv_l, drv_c, drv_r;
  logic [7:0] drv_a, drv_b;

  pe_mac_param_if #(.DATA_W(8), .ACC_W(32)) ifc0 ();
  pe_mac_param_if #(.DATA_W(8), .ACC_W(16)) ifc1 ();
  pe_mac_param_if #(.DATA_W(8), .ACC_W(16)) ifc2 ();
  pe_mac_param_if #(.DATA_W(8), .ACC_W(32)) ifc3 ();

  pe_mac_param #(.DATA_W(8), .ACC_W(32), .SIGNED(0), .SATURATE(1), .PIPE_MUL(1))
    u_dut0 (.i_clk(clk), .i_arst_n(rst_n), .bus(ifc0));
  pe_mac_param #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(1), .PIPE_MUL(1))
    u_dut1 (.i_clk(clk), .i_arst_n(rst_n), .bus(ifc1));
  pe_mac_param #(.DATA_W(8), .ACC_W(16), .SIGNED(1), .SATURATE(0), .PIPE_MUL(1))
    u_dut2 (.i_clk(clk), .i_arst_n(rst_n), .bus(ifc2));
  pe_mac_param #(.DATA_W(8), .ACC_W(32), .SIGNED(0), .SATURATE(1), .PIPE_MUL(0))
    u_dut3 (.i_clk(clk), .i_arst_n(rst_n), .bus(ifc3));

  assign ifc0.i_valid = drv_v; assign ifc0.i_last = drv_l; assign ifc0.i_clear = drv_c;
  assign ifc0.i_a = drv_a;     assign ifc0.i_b = drv_b;    assign ifc0.i_yReady = drv_r;
  assign ifc1.i_valid = drv_v; assign ifc1.i_last = drv_l; assign ifc1.i_clear = drv_c;
  assign ifc1.i_a = drv_a;     assign ifc1.i_b = drv_b;    assign ifc1.i_yReady = drv_r;
  assign ifc2.i_valid = drv_v; assign ifc2.i_last = drv_l; assign ifc2.i_clear = drv_c;
  assign ifc2.i_a = drv_a;     assign ifc2.i_b = drv_b;    assign ifc2.i_yReady = drv_r;
  assign ifc3.i_valid = drv_v; assign ifc3.i_last = drv_l; assign ifc3.i_clear = drv_c;
  assign ifc3.i_a = drv_a;     assign ifc3.i_b = drv_b;    assign ifc3.i_yReady = drv_r;

  logic [31:0] obs_y   [NCFG];
  logic        obs_yv  [NCFG];
  logic        obs_ovf [NCFG];
  logic        obs_ovr [NCFG];
  logic        obs_v   [NCFG];
  logic        obs_l   [NCFG];
  logic [7:0]  obs_a   [NCFG];
  logic [7:0]  obs_b   [NCFG];

  assign obs_y[0] = ifc0.o_y;        assign obs_y[1] = 32'(ifc1.o_y);
  assign obs_y[2] = 32'(ifc2.o_y);   assign obs_y[3] = ifc3.o_y;
  assign obs_yv[0] = ifc0.o_yValid;  assign obs_yv[1] = ifc1.o_yValid;
  assign obs_yv[2] = ifc2.o_yValid;  assign obs_yv[3] = ifc3.o_yValid;
  assign obs_ovf[0] = ifc0.o_yOvf;   assign obs_ovf[1] = ifc1.o_yOvf;
  assign obs_ovf[2] = ifc2.o_yOvf;   assign obs_ovf[3] = ifc3.o_yOvf;
  assign obs_ovr[0] = ifc0.o_overrun; assign obs_ovr[1] = ifc1.o_overrun;
  assign obs_ovr[2] = ifc2.o_overrun; assign obs_ovr[3] = ifc3.o_overrun;
  assign obs_v[0] = ifc0.o_valid;    assign obs_v[1] = ifc1.o_valid;
  assign obs_v[2] = ifc2.o_valid;    assign obs_v[3] = ifc3.o_valid;
  assign obs_l[0] = ifc0.o_last;     assign obs_l[1] = ifc1.o_last;
  assign obs_l[2] = ifc2.o_last;     assign obs_l[3] = ifc3.o_last;
  assign obs_a[0] = ifc0.o_a;        assign obs_a[1] = ifc1.o_a;
  assign obs_a[2] = ifc2.o_a;        assign obs_a[3] = ifc3.o_a;
  assign obs_b[0] = ifc0.o_b;        assign obs_b[1] = ifc1.o_b;
  assign obs_b[2] = ifc2.o_b;        assign obs_b[3] = ifc3.o_b;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Terms of the open tile are kept as exact integers; a tile is folded term by term when its
  // last term reaches the accumulator, clamping or wrapping into the configured range.
  longint      terms  [NCFG][$];
  bit          stg_v  [NCFG];
  longint      stg_p  [NCFG];
  bit          stg_l  [NCFG];
  logic [31:0] exp_y  [NCFG];
  bit          exp_yv [NCFG];
  bit          exp_ovf[NCFG];
  bit          exp_ovr[NCFG];
  bit          exp_fv, exp_fl;
  logic [7:0]  exp_fa, exp_fb;

  function automatic longint product(input int c, input logic [7:0] a, input logic [7:0] b);
    if (CFG_S[c] != 0) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  task automatic fold(input int c, output logic [31:0] y, output bit ovf);
    longint w, hi, lo, m, acc, s;
    w   = CFG_W[c];
    m   = longint'(1) << w;
    hi  = (CFG_S[c] != 0) ? (m / 2) - 1 : m - 1;
    lo  = (CFG_S[c] != 0) ? -(m / 2) : 0;
    acc = terms[c][0];
    ovf = 1'b0;
    for (int i = 1; i < terms[c].size(); i++) begin
      s = acc + terms[c][i];
      if (s > hi || s < lo) begin
        ovf = 1'b1;
        if (CFG_SAT[c] != 0) s = (s > hi) ? hi : lo;
        else begin
          s = s % m;
          if (s < 0) s += m;
          if (s > hi) s -= m;
        end
      end
      acc = s;
    end
    y = 32'(acc & (m - 1));
  endtask

  task automatic model_reset();
    exp_fv = 0; exp_fl = 0; exp_fa = '0; exp_fb = '0;
    for (int c = 0; c < NCFG; c++) begin
      terms[c].delete();
      stg_v[c] = 0; stg_p[c] = 0; stg_l[c] = 0;
      exp_y[c] = '0; exp_yv[c] = 0; exp_ovf[c] = 0; exp_ovr[c] = 0;
    end
  endtask

  task automatic model_step(input bit v, input bit l, input bit clr, input logic [7:0] a,
                            input logic [7:0] b, input bit rdy);
    longint      p, tp;
    bit          tv, tl, load, fovf;
    logic [31:0] fy;
    exp_fv = v;
    if (v) begin exp_fa = a; exp_fb = b; exp_fl = l; end
    for (int c = 0; c < NCFG; c++) begin
      p = product(c, a, b);
      if (CFG_P[c] != 0) begin
        tv = stg_v[c]; tp = stg_p[c]; tl = stg_l[c];
        stg_v[c] = v && !clr;
        if (v) begin stg_p[c] = p; stg_l[c] = l; end
      end else begin
        tv = v; tp = p; tl = l;
      end
      load = 0; fy = '0; fovf = 0;
      if (clr) terms[c].delete();
      else if (tv) begin
        terms[c].push_back(tp);
        if (tl) begin
          fold(c, fy, fovf);
          terms[c].delete();
          load = 1;
        end
      end
      exp_ovr[c] = load && exp_yv[c] && !rdy;
      if (load) begin exp_y[c] = fy; exp_ovf[c] = fovf; exp_yv[c] = 1; end
      else if (exp_yv[c] && rdy) exp_yv[c] = 0;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d o_y", c),       obs_y[c],         exp_y[c]);
      check($sformatf("cfg%0d o_yValid", c),  32'(obs_yv[c]),   32'(exp_yv[c]));
      check($sformatf("cfg%0d o_yOvf", c),    32'(obs_ovf[c]),  32'(exp_ovf[c]));
      check($sformatf("cfg%0d o_overrun", c), 32'(obs_ovr[c]),  32'(exp_ovr[c]));
      check($sformatf("cfg%0d o_valid", c),   32'(obs_v[c]),    32'(exp_fv));
      check($sformatf("cfg%0d o_last", c),    32'(obs_l[c]),    32'(exp_fl));
      check($sformatf("cfg%0d o_a", c),       32'(obs_a[c]),    32'(exp_fa));
      check($sformatf("cfg%0d o_b", c),       32'(obs_b[c]),    32'(exp_fb));
    end
  endtask

  // Inputs are driven at the falling edge, the rising edge samples them, outputs are
  // compared 1 time unit later; the task returns at the next falling edge.
  task automatic step(input bit v, input bit l, input bit clr, input logic [7:0] a,
                      input logic [7:0] b, input bit rdy);
    drv_v = v; drv_l = l; drv_c = clr; drv_a = a; drv_b = b; drv_r = rdy;
    model_step(v, l, clr, a, b, rdy);
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  function automatic logic [7:0] pick();
    case ($urandom_range(0, 3))
      0:       return 8'h80;
      1:       return 8'h7f;
      2:       return 8'hff;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    drv_v = 0; drv_l = 0; drv_c = 0; drv_a = '0; drv_b = '0; drv_r = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();                               // reset state
    rst_n = 1'b1;

    // Tile {1*4, 2*5, 3*6} = 32; the unpipelined cell shows the result one edge earlier.
    step(1, 0, 0, 8'd1, 8'd4, 1);
    check("t1 o_a echo", 32'(obs_a[0]), 32'd1);
    check("t1 o_b echo", 32'(obs_b[0]), 32'd4);
    step(1, 0, 0, 8'd2, 8'd5, 1);
    step(1, 1, 0, 8'd3, 8'd6, 1);
    check("t6 nopipe yValid early", 32'(obs_yv[3]), 32'd1);
    check("t6 nopipe y", obs_y[3], 32'd32);
    check("t6 pipe yValid not yet", 32'(obs_yv[0]), 32'd0);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    check("t1 y", obs_y[0], 32'd32);
    check("t1 yValid", 32'(obs_yv[0]), 32'd1);
    check("t1 yOvf", 32'(obs_ovf[0]), 32'd0);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    check("t1 yValid one cycle", 32'(obs_yv[0]), 32'd0);

    // Three (-128)*(-128) terms: saturate vs wrap in 16 signed bits.
    step(1, 0, 0, 8'h80, 8'h80, 1);
    step(1, 0, 0, 8'h80, 8'h80, 1);
    step(1, 1, 0, 8'h80, 8'h80, 1);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    check("t2 sat y", obs_y[1], 32'h7fff);
    check("t2 sat ovf", 32'(obs_ovf[1]), 32'd1);
    check("t2 wrap y", obs_y[2], 32'hc000);
    check("t2 wrap ovf", 32'(obs_ovf[2]), 32'd1);
    check("t2 unsigned y", obs_y[0], 32'd49152);
    step(0, 0, 0, 8'd0, 8'd0, 1);

    // Back-to-back single-term tiles with the consumer stalled, then with ready on 2nd load.
    step(1, 1, 0, 8'd3, 8'd3, 0);
    step(1, 1, 0, 8'd2, 8'd2, 0);
    step(0, 0, 0, 8'd0, 8'd0, 0);
    check("t3 overrun", 32'(obs_ovr[0]), 32'd1);
    check("t3 y overwritten", obs_y[0], 32'd4);
    step(0, 0, 0, 8'd0, 8'd0, 0);
    check("t3 overrun pulse ends", 32'(obs_ovr[0]), 32'd0);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    step(1, 1, 0, 8'd3, 8'd3, 0);
    step(1, 1, 0, 8'd2, 8'd2, 0);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    check("t3 pop+load no overrun", 32'(obs_ovr[0]), 32'd0);
    check("t3 pop+load yValid", 32'(obs_yv[0]), 32'd1);
    check("t3 pop+load y", obs_y[0], 32'd4);

    // Clear after the second 5*5 term discards the partial sum.
    step(1, 0, 0, 8'd5, 8'd5, 1);
    step(1, 0, 0, 8'd5, 8'd5, 1);
    step(0, 0, 1, 8'd0, 8'd0, 1);
    step(1, 1, 0, 8'd1, 8'd1, 1);
    step(0, 0, 0, 8'd0, 8'd0, 0);
    check("t4 y after clear", obs_y[0], 32'd1);
    check("t4 yValid", 32'(obs_yv[0]), 32'd1);

    // Asynchronous reset in the middle of a tile while a result is held.
    step(1, 0, 0, 8'd7, 8'd3, 0);
    step(1, 0, 0, 8'd2, 8'd2, 0);
    check("t5 held before reset", 32'(obs_yv[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check("t5 async yValid", 32'(obs_yv[0]), 32'd0);
    drv_v = 0; drv_l = 0; drv_c = 0; drv_r = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 1, 0, 8'd7, 8'd7, 1);
    step(0, 0, 0, 8'd0, 8'd0, 1);
    check("t5 y after reset", obs_y[0], 32'd49);

    // Random traffic biased toward extreme operands to exercise clamping and wrapping.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
           pick(), pick(), $urandom_range(0, 1) == 1);
    end
    repeat (3) step(0, 0, 0, 8'd0, 8'd0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
